// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the dual-issue scheduler: control-word layout,
// instruction register-field positions and the scheduler state encoding.
package issue_scheduler_pkg;

    // Control word layout (bit index): 0 LUI, 1 AUIPC, 2 JAL, 3 JALR,
    // 4 BRANCH, 5 ALUI, 6 ALUR, 7 REGWRITE. All-zero means bubble.
    localparam int unsigned CTRL_WIDTH    = 8;
    localparam int unsigned CTRL_JAL      = 2;
    localparam int unsigned CTRL_JALR     = 3;
    localparam int unsigned CTRL_BRANCH   = 4;
    localparam int unsigned CTRL_ALUI     = 5;
    localparam int unsigned CTRL_ALUR     = 6;
    localparam int unsigned CTRL_REGWRITE = 7;

    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_MSB = 19;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_MSB = 24;
    localparam int unsigned RS2_LSB = 20;

    typedef enum logic {
        SCHED_PAIR  = 1'b0,
        SCHED_SPLIT = 1'b1
    } sched_state_e;

    function automatic logic reads_rs1(input logic [CTRL_WIDTH-1:0] c);
        return c[CTRL_JALR] | c[CTRL_ALUI] | c[CTRL_BRANCH] | c[CTRL_ALUR];
    endfunction

    function automatic logic reads_rs2(input logic [CTRL_WIDTH-1:0] c);
        return c[CTRL_BRANCH] | c[CTRL_ALUR];
    endfunction

    function automatic logic is_ctrl_flow(input logic [CTRL_WIDTH-1:0] c);
        return c[CTRL_BRANCH] | c[CTRL_JAL] | c[CTRL_JALR];
    endfunction

endpackage

// File: rtl/sched_hazard_check.sv
// Combinational pair hazard check: decides whether slot 1 must be held back
// a cycle (RAW, WAW, or slot 1 needing the lane-0 branch unit).
module sched_hazard_check
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_WIDTH,
    parameter int unsigned XLEN   = 32
) (
    input  logic [CTRL_W-1:0] s0_ctrl_i,
    input  logic [XLEN-1:0]   s0_inst_i,
    input  logic [CTRL_W-1:0] s1_ctrl_i,
    input  logic [XLEN-1:0]   s1_inst_i,
    output logic              split_o,
    output logic              s0_bubble_o
);

    logic [4:0] s0_rd;
    logic [4:0] s1_rd;
    logic [4:0] s1_rs1;
    logic [4:0] s1_rs2;
    logic       s0_writes;
    logic       s1_writes;
    logic       raw;
    logic       waw;
    logic       both_live;
    logic       unused_inst_bits;

    assign s0_rd  = s0_inst_i[RD_MSB:RD_LSB];
    assign s1_rd  = s1_inst_i[RD_MSB:RD_LSB];
    assign s1_rs1 = s1_inst_i[RS1_MSB:RS1_LSB];
    assign s1_rs2 = s1_inst_i[RS2_MSB:RS2_LSB];

    assign s0_writes = s0_ctrl_i[CTRL_REGWRITE] && (s0_rd != '0);
    assign s1_writes = s1_ctrl_i[CTRL_REGWRITE] && (s1_rd != '0);

    assign raw = s0_writes &&
                 ((reads_rs1(s1_ctrl_i) && (s1_rs1 == s0_rd)) ||
                  (reads_rs2(s1_ctrl_i) && (s1_rs2 == s0_rd)));
    assign waw = s0_writes && s1_writes && (s0_rd == s1_rd);

    assign both_live   = (s0_ctrl_i != '0) && (s1_ctrl_i != '0);
    assign split_o     = both_live && (raw || waw || is_ctrl_flow(s1_ctrl_i));
    assign s0_bubble_o = (s0_ctrl_i == '0);

    assign unused_inst_bits = ^{s0_inst_i[XLEN-1:RD_MSB+1], s0_inst_i[RD_LSB-1:0],
                                s1_inst_i[XLEN-1:RS2_MSB+1], s1_inst_i[RD_LSB-1:0]};

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: issues independent pairs together, splits dependent
// pairs over two cycles. Optional perf counters under `SCHED_PERF_CNT_EN`.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_WIDTH,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [CTRL_W-1:0] s0_ctrl_i,
    input  logic [XLEN-1:0]   s0_inst_i,
    input  logic [XLEN-1:0]   s0_pc_i,
    input  logic [CTRL_W-1:0] s1_ctrl_i,
    input  logic [XLEN-1:0]   s1_inst_i,
    input  logic [XLEN-1:0]   s1_pc_i,
    input  logic              pair_valid_i,
    output logic              pair_ready_o,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              l0_valid_o,
    output logic [CTRL_W-1:0] l0_ctrl_o,
    output logic [XLEN-1:0]   l0_inst_o,
    output logic [XLEN-1:0]   l0_pc_o,
    output logic              l1_valid_o,
    output logic [CTRL_W-1:0] l1_ctrl_o,
    output logic [XLEN-1:0]   l1_inst_o,
    output logic [XLEN-1:0]   l1_pc_o,
    output logic [31:0]       dual_cnt_o,
    output logic [31:0]       split_cnt_o
);

    logic split;
    logic s0_bubble;

    sched_hazard_check #(
        .CTRL_W (CTRL_W),
        .XLEN   (XLEN)
    ) u_hazard (
        .s0_ctrl_i   (s0_ctrl_i),
        .s0_inst_i   (s0_inst_i),
        .s1_ctrl_i   (s1_ctrl_i),
        .s1_inst_i   (s1_inst_i),
        .split_o     (split),
        .s0_bubble_o (s0_bubble)
    );

    sched_state_e      state_q, state_d;
    logic [CTRL_W-1:0] hold_ctrl_q, hold_ctrl_d;
    logic [XLEN-1:0]   hold_inst_q, hold_inst_d;
    logic [XLEN-1:0]   hold_pc_q,   hold_pc_d;
    logic              l0_valid_d, l1_valid_d;
    logic [CTRL_W-1:0] l0_ctrl_d,  l1_ctrl_d;
    logic [XLEN-1:0]   l0_inst_d,  l1_inst_d;
    logic [XLEN-1:0]   l0_pc_d,    l1_pc_d;
    logic              accept;
    logic              fill_both;
    logic              enter_split;

    always_comb begin
        state_d      = state_q;
        hold_ctrl_d  = hold_ctrl_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        l0_valid_d   = l0_valid_o;
        l0_ctrl_d    = l0_ctrl_o;
        l0_inst_d    = l0_inst_o;
        l0_pc_d      = l0_pc_o;
        l1_valid_d   = l1_valid_o;
        l1_ctrl_d    = l1_ctrl_o;
        l1_inst_d    = l1_inst_o;
        l1_pc_d      = l1_pc_o;
        fill_both    = 1'b0;
        enter_split  = 1'b0;
        pair_ready_o = rstn_i && (state_q == SCHED_PAIR) && !stall_i && !flush_i;
        accept       = pair_valid_i && pair_ready_o;

        if (flush_i) begin
            state_d     = SCHED_PAIR;
            l0_valid_d  = 1'b0;
            l1_valid_d  = 1'b0;
            hold_ctrl_d = '0;
            hold_inst_d = '0;
            hold_pc_d   = '0;
        end else if (!stall_i) begin
            case (state_q)
                SCHED_PAIR: begin
                    if (!accept) begin
                        l0_valid_d = 1'b0;
                        l1_valid_d = 1'b0;
                    end else if (s0_bubble) begin
                        // slot 1 slides down to lane 0 so it keeps the branch unit
                        l0_valid_d = (s1_ctrl_i != '0);
                        l0_ctrl_d  = s1_ctrl_i;
                        l0_inst_d  = s1_inst_i;
                        l0_pc_d    = s1_pc_i;
                        l1_valid_d = 1'b0;
                    end else begin
                        l0_valid_d = 1'b1;
                        l0_ctrl_d  = s0_ctrl_i;
                        l0_inst_d  = s0_inst_i;
                        l0_pc_d    = s0_pc_i;
                        if (split) begin
                            l1_valid_d  = 1'b0;
                            hold_ctrl_d = s1_ctrl_i;
                            hold_inst_d = s1_inst_i;
                            hold_pc_d   = s1_pc_i;
                            state_d     = SCHED_SPLIT;
                            enter_split = 1'b1;
                        end else begin
                            l1_valid_d = (s1_ctrl_i != '0);
                            l1_ctrl_d  = s1_ctrl_i;
                            l1_inst_d  = s1_inst_i;
                            l1_pc_d    = s1_pc_i;
                            fill_both  = (s1_ctrl_i != '0);
                        end
                    end
                end
                SCHED_SPLIT: begin
                    l0_valid_d = (hold_ctrl_q != '0);
                    l0_ctrl_d  = hold_ctrl_q;
                    l0_inst_d  = hold_inst_q;
                    l0_pc_d    = hold_pc_q;
                    l1_valid_d = 1'b0;
                    state_d    = SCHED_PAIR;
                end
                default: state_d = SCHED_PAIR;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= SCHED_PAIR;
            hold_ctrl_q <= '0;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
            l0_valid_o  <= 1'b0;
            l0_ctrl_o   <= '0;
            l0_inst_o   <= '0;
            l0_pc_o     <= '0;
            l1_valid_o  <= 1'b0;
            l1_ctrl_o   <= '0;
            l1_inst_o   <= '0;
            l1_pc_o     <= '0;
        end else begin
            state_q     <= state_d;
            hold_ctrl_q <= hold_ctrl_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            l0_valid_o  <= l0_valid_d;
            l0_ctrl_o   <= l0_ctrl_d;
            l0_inst_o   <= l0_inst_d;
            l0_pc_o     <= l0_pc_d;
            l1_valid_o  <= l1_valid_d;
            l1_ctrl_o   <= l1_ctrl_d;
            l1_inst_o   <= l1_inst_d;
            l1_pc_o     <= l1_pc_d;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] dual_cnt_q;
    logic [31:0] split_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            dual_cnt_q  <= '0;
            split_cnt_q <= '0;
        end else begin
            if (fill_both)   dual_cnt_q  <= dual_cnt_q + 32'd1;
            if (enter_split) split_cnt_q <= split_cnt_q + 32'd1;
        end
    end

    assign dual_cnt_o  = dual_cnt_q;
    assign split_cnt_o = split_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = fill_both ^ enter_split;
    assign dual_cnt_o  = '0;
    assign split_cnt_o = '0;
`endif

endmodule
